// File: rtl/npu_wb_pkg.sv
// ============================================================================
// Module      : npu_wb_pkg
// Description : Shared types and helpers for the systolic write-back path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package npu_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } wb_state_t;

    localparam int DEFAULT_LANES        = 4;
    localparam int DEFAULT_DESKEW_DEPTH = DEFAULT_LANES - 1;

    // Lane 0 waits for the last lane, which arrives lanes-1 cycles later.
    function automatic int deskew_depth(input int lanes);
        return lanes - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/streaming_deskewer.sv
// ============================================================================
// Module      : streaming_deskewer
// Description : Per-lane delay lines that realign a skewed N-lane stream.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module streaming_deskewer
    import npu_wb_pkg::*;
#(
    parameter int N          = DEFAULT_LANES,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic [N*DATA_WIDTH-1:0] i_data,
    input  logic                    i_valid,
    input  logic                    i_first,
    input  logic                    i_last,
    output logic [N*DATA_WIDTH-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_first,
    output logic                    o_last
);

    localparam int DEPTH = deskew_depth(N);

    generate
        for (genvar g = 0; g < N; g++) begin : g_lane
            localparam int LANE_DEPTH = DEPTH - g;

            if (LANE_DEPTH == 0) begin : g_pass
                assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = i_data[g*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pipe
                logic [DATA_WIDTH-1:0] r_pipe [LANE_DEPTH];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < LANE_DEPTH; k++) begin
                            r_pipe[k] <= '0;
                        end
                    end else if (i_en) begin
                        r_pipe[0] <= i_data[g*DATA_WIDTH +: DATA_WIDTH];
                        for (int k = 1; k < LANE_DEPTH; k++) begin
                            r_pipe[k] <= r_pipe[k-1];
                        end
                    end
                end

                assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = r_pipe[LANE_DEPTH-1];
            end
        end

        // Framing travels with lane 0, so it takes the full deskew depth.
        if (DEPTH == 0) begin : g_ctrl_pass
            assign o_valid = i_valid;
            assign o_first = i_first;
            assign o_last  = i_last;
        end else begin : g_ctrl_pipe
            logic [2:0] r_ctrl [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_ctrl[k] <= '0;
                    end
                end else if (i_en) begin
                    r_ctrl[0] <= {i_valid, i_first, i_last};
                    for (int k = 1; k < DEPTH; k++) begin
                        r_ctrl[k] <= r_ctrl[k-1];
                    end
                end
            end

            assign {o_valid, o_first, o_last} = r_ctrl[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/output_deskew_writer.sv
// ============================================================================
// Module      : output_deskew_writer
// Description : Deskews systolic results and writes packed rows to the UB.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module output_deskew_writer
    import npu_wb_pkg::*;
#(
    parameter int N            = DEFAULT_LANES,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int BUFFER_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     max_rows,
    input  logic [N*DATA_WIDTH-1:0] data_in_flat,
    input  logic                    valid_in,
    input  logic                    first_in,
    input  logic                    last_in,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [BUFFER_WIDTH-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic                    proto_err
);

    generate
        if (BUFFER_WIDTH != N*DATA_WIDTH) begin : g_bad_width
            $error("output_deskew_writer: BUFFER_WIDTH must equal N*DATA_WIDTH");
        end
    endgenerate

    logic [BUFFER_WIDTH-1:0] w_al_data;
    logic                    w_al_valid;
    logic                    w_al_first;
    logic                    w_al_last;

    streaming_deskewer #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deskew (
        .clk     (clk),
        .rst     (rst),
        .i_en    (en),
        .i_data  (data_in_flat),
        .i_valid (valid_in),
        .i_first (first_in),
        .i_last  (last_in),
        .o_data  (w_al_data),
        .o_valid (w_al_valid),
        .o_first (w_al_first),
        .o_last  (w_al_last)
    );

    wb_state_t               r_state;
    wb_state_t               w_next_state;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH:0]     r_max;
    logic [ADDR_WIDTH:0]     r_cnt;
    logic [ADDR_WIDTH:0]     w_cnt_next;
    logic                    r_overrun;
    logic                    r_proto_err;
    logic                    r_done;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [BUFFER_WIDTH-1:0] r_wr_data;
    logic                    w_wr_en;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic                    w_set_over;
    logic                    w_set_proto;
    logic                    w_start_acc;
    logic                    w_budget_hit;

    // The job stays busy through the done pulse, so a new start waits for it.
    assign w_start_acc  = start && (r_state == IDLE) && !r_done;
    assign w_budget_hit = (r_max != '0) && (r_cnt == r_max);

    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_base + r_cnt[ADDR_WIDTH-1:0];
        w_cnt_next   = r_cnt;
        w_set_over   = 1'b0;
        w_set_proto  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start_acc) begin
                    w_next_state = ARMED;
                end
            end
            ARMED: begin
                if (w_al_valid) begin
                    if (w_al_first) begin
                        w_wr_en      = 1'b1;
                        w_wr_addr    = r_base;
                        w_cnt_next   = (ADDR_WIDTH+1)'(1);
                        w_next_state = w_al_last ? DONE : STREAM;
                    end else begin
                        w_set_proto = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (w_al_valid) begin
                    w_set_proto = w_al_first;
                    if (w_budget_hit) begin
                        w_set_over = 1'b1;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_cnt_next = r_cnt + (ADDR_WIDTH+1)'(1);
                    end
                    if (w_al_last) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_max       <= '0;
            r_cnt       <= '0;
            r_overrun   <= 1'b0;
            r_proto_err <= 1'b0;
            r_done      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else if (en) begin
            r_state <= w_next_state;
            r_done  <= (r_state == DONE);
            r_wr_en <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_al_data;
            end
            if (w_start_acc) begin
                r_base      <= base_addr;
                r_max       <= max_rows;
                r_cnt       <= '0;
                r_overrun   <= 1'b0;
                r_proto_err <= 1'b0;
            end else begin
                r_cnt       <= w_cnt_next;
                r_overrun   <= r_overrun | w_set_over;
                r_proto_err <= r_proto_err | w_set_proto;
            end
        end
    end

    assign wr_en     = r_wr_en & en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign done      = r_done & en;
    assign busy      = (r_state != IDLE) | r_done;
    assign overrun   = r_overrun;
    assign proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: doc/output_deskew_writer.md
Name: output_deskew_writer

Overview:
Write-back end of the systolic datapath; the inverse of the input/weight skew path.
- Accepts the skewed N-lane result stream leaving the systolic array and removes the per-lane skew.
- Packs each aligned row into one BUFFER_WIDTH word.
- Writes rows into the unified buffer through its write port (wr_en/wr_addr/wr_data) at consecutive addresses from a latched base.
- A start/busy/done handshake lets the controller sequence write-back.

Parameters:
N, `ARRAY_SIZE, number of lanes.
DATA_WIDTH, `DATA_WIDTH, bits per lane.
ADDR_WIDTH, `ADDR_WIDTH, UB address width.
BUFFER_WIDTH, `BUFFER_WIDTH, UB word width; must equal N*DATA_WIDTH (elaboration-time assertion).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  pipeline advance; 0 = hold all deskew/state registers, no writes.
start  in  1  one-cycle request to arm a write-back job.
base_addr  in  ADDR_WIDTH  first UB row address, sampled on accepted start.
max_rows  in  ADDR_WIDTH+1  row budget, sampled on accepted start; 0 = unlimited.
data_in_flat  in  N*DATA_WIDTH  skewed lanes; lane i = bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
valid_in  in  1  row-valid, aligned with lane 0.
first_in  in  1  first row of tile, aligned with lane 0.
last_in  in  1  last row of tile, aligned with lane 0.
wr_en  out  1  UB write strobe.
wr_addr  out  ADDR_WIDTH  UB write address.
wr_data  out  BUFFER_WIDTH  deskewed packed row, lane i in the same bit slice.
busy  out  1  job armed or streaming.
done  out  1  one-cycle pulse after the final write.
overrun  out  1  sticky: budget exceeded; cleared on accepted start.
proto_err  out  1  sticky: framing violation; cleared on accepted start.

Behaviour:
- Reset: every output and all internal registers go to 0; state goes to IDLE; deskew pipes are flushed. Reset asserted mid-job abandons the job with no further writes.
- Input skew convention: the element of row r on lane i arrives i cycles after lane 0 (counted in en=1 cycles).
- Deskew: lane i is delayed by N-1-i registered stages. valid/first/last are delayed N-1 stages. All signals are therefore aligned at stage N-1 ("aligned row").
- Output timing: one output register stage follows alignment. Latency from lane-0 input to wr_en is N en-cycles. en=0 freezes every stage and forces wr_en=0 that cycle.
- FSM: IDLE -> ARMED -> STREAM -> DONE -> IDLE.
  - IDLE: busy=0. start latches base_addr and max_rows, clears cnt/overrun/proto_err, and moves to ARMED. Aligned rows arriving in IDLE are dropped silently.
  - ARMED: busy=1. An aligned valid row with first writes at base_addr, sets cnt=1, and moves to STREAM; if that row also has last, go to DONE instead. An aligned valid row without first is dropped and sets proto_err.
  - STREAM: each aligned valid row writes at base_addr+cnt (ADDR_WIDTH modulo, wraps silently), then cnt++. Aligned first in STREAM sets proto_err and the row is still written as data. Aligned last writes the row and moves to DONE.
  - DONE: done=1 for one cycle; busy=1 in this cycle, then return to IDLE.
- Budget: if max_rows!=0 and cnt==max_rows, further rows are not written (wr_en=0) and overrun is set. Reaching last still goes to DONE.
- start while busy is ignored, and parameters are not re-sampled.
- Simultaneous start and aligned row in IDLE: start takes effect; the row is dropped.

Decomposition:
- Package npu_wb_pkg holds the state enum (IDLE, ARMED, STREAM, DONE) and a localparam for deskew depth (N-1).
- One sub-module, streaming_deskewer: parameterised per-lane delay line with en stall, plus the first/last/valid delay.
- Top level holds the FSM, address counter and write-port register.

Test Plan:
All scenarios use N=4, DATA_WIDTH=8.
1. Single-row job: start, base=0x10. Send lane-skewed row {0x44,0x33,0x22,0x11} with first=last=1 -> wr_en 4 cycles after lane 0, wr_addr=0x10, wr_data=0x44332211, done one cycle after the write.
2. Four-row tile: base=0x3E, max_rows=0, rows back-to-back -> writes to 0x3E, 0x3F, 0x40, 0x41 with correct packing; busy high throughout; done once.
3. Stall: drop en for 3 cycles in mid-stream -> no wr_en during the stall; every row is still written intact, in order, to the correct address.
4. Budget: max_rows=2, send 4 rows -> 2 writes, overrun=1, done pulses after the row carrying last.
5. Framing: in ARMED send a row without first -> no write, proto_err=1. Next start -> proto_err=0.
6. Reset mid-stream: assert rst after 2 of 4 rows -> all outputs 0 immediately. After release, no write for residual rows; state IDLE.
